// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup, registered update, no backpressure.
// Optional statistics counters and upd_pred_taken port are compiled in when BTB_STATS_EN is defined.
module branch_predictor_btb #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned TAG_W     = 16,
  parameter logic [1:0]  CNT_ALLOC = 2'b10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            flush_all
`ifdef BTB_STATS_EN
  ,
  input  logic            upd_pred_taken,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [XLEN-1:0]   tgt_q   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [TAG_W-1:0]  upd_tag;
  logic              lk_hit;
  logic              upd_hit;
  logic              upd_wr;
  logic [1:0]        ctr_d;

  assign lk_idx  = lookup_pc[2 +: IDX_W];
  assign lk_tag  = lookup_pc[2+IDX_W +: TAG_W];
  assign upd_idx = upd_pc[2 +: IDX_W];
  assign upd_tag = upd_pc[2+IDX_W +: TAG_W];

  // Lookup reads stored state only; an update in the same cycle is seen one cycle later.
  assign lk_hit      = lookup_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_hit    = lk_hit;
  assign pred_taken  = lk_hit & ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + XLEN'(4);

  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  // Not-taken misses never allocate, so only hits or taken branches write the entry.
  assign upd_wr  = upd_valid & ~flush_all & (upd_hit | upd_taken);

  always_comb begin
    ctr_d = CNT_ALLOC;
    if (upd_hit) begin
      if (upd_taken) begin
        ctr_d = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
      end else begin
        ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (flush_all) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_wr) begin
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      ctr_q[upd_idx]   <= ctr_d;
      if (upd_taken) begin
        tgt_q[upd_idx] <= upd_target;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q;
  logic [31:0] stat_updates_q;
  logic [31:0] stat_mispred_q;
  logic        upd_counts;

  assign upd_counts = upd_valid & ~flush_all;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lookups_q <= '0;
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (lookup_valid && stat_lookups_q != 32'hFFFF_FFFF) begin
        stat_lookups_q <= stat_lookups_q + 32'd1;
      end
      if (upd_counts && stat_updates_q != 32'hFFFF_FFFF) begin
        stat_updates_q <= stat_updates_q + 32'd1;
      end
      if (upd_counts && (upd_pred_taken != upd_taken) && stat_mispred_q != 32'hFFFF_FFFF) begin
        stat_mispred_q <= stat_mispred_q + 32'd1;
      end
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_updates = stat_updates_q;
  assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Randomized bench for branch_predictor_btb against an entry-level behavioural model.
module tb_branch_predictor_btb;

  localparam int NENT = 16;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [63:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        flush_all;
  logic        upd_pred_taken;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model state: one record per direct-mapped slot.
  bit          m_v   [NENT];
  longint      m_tag [NENT];
  logic [63:0] m_tgt [NENT];
  int          m_ctr [NENT];
  longint      m_lk, m_up, m_mis;

  branch_predictor_btb #(
    .XLEN(64), .ENTRIES(16), .TAG_W(16), .CNT_ALLOC(2'b10)
  ) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .flush_all(flush_all)
`ifdef BTB_STATS_EN
    , .upd_pred_taken(upd_pred_taken),
    .stat_lookups(stat_lookups), .stat_updates(stat_updates), .stat_mispred(stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_idx(input logic [63:0] pc);
    return int'((pc >> 2) % 64'(NENT));
  endfunction

  function automatic longint m_tg(input logic [63:0] pc);
    return longint'((pc >> 6) % 64'd65536);
  endfunction

  function automatic longint sat_inc(input longint v);
    return (v >= 64'sh0_FFFF_FFFF) ? 64'sh0_FFFF_FFFF : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_lk = 0; m_up = 0; m_mis = 0;
  endtask

  // Compare outputs against the model for the inputs currently applied.
  task automatic check_model();
    int     i;
    bit     hit, tk;
    logic [63:0] tgt;
    i   = m_idx(lookup_pc);
    hit = lookup_valid && m_v[i] && (m_tag[i] == m_tg(lookup_pc));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : lookup_pc + 64'd4;
    chk("hit", 64'(pred_hit), 64'(hit));
    chk("taken", 64'(pred_taken), 64'(tk));
    chk("target", pred_target, tgt);
`ifdef BTB_STATS_EN
    chk("stat_lookups", 64'(stat_lookups), 64'(m_lk));
    chk("stat_updates", 64'(stat_updates), 64'(m_up));
    chk("stat_mispred", 64'(stat_mispred), 64'(m_mis));
`endif
  endtask

  // Apply the clock edge's effect to the model using the inputs held across it.
  task automatic model_edge();
    int i;
    if (lookup_valid) m_lk = sat_inc(m_lk);
    if (flush_all) begin
      for (int k = 0; k < NENT; k++) m_v[k] = 0;
    end else if (upd_valid) begin
      m_up = sat_inc(m_up);
      if (upd_pred_taken != upd_taken) m_mis = sat_inc(m_mis);
      i = m_idx(upd_pc);
      if (m_v[i] && m_tag[i] == m_tg(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_v[i] = 1; m_tag[i] = m_tg(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = 2;
      end
    end
  endtask

  task automatic drive(input logic lv, input logic [63:0] lpc, input logic uv,
                       input logic [63:0] upc, input logic ut, input logic [63:0] utg,
                       input logic fl, input logic upt);
    @(negedge clk);
    lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    flush_all = fl; upd_pred_taken = upt;
    #1;
  endtask

  task automatic step(input logic lv, input logic [63:0] lpc, input logic uv,
                      input logic [63:0] upc, input logic ut, input logic [63:0] utg,
                      input logic fl, input logic upt);
    drive(lv, lpc, uv, upc, ut, utg, fl, upt);
    check_model();
    @(posedge clk);
    model_edge();
  endtask

  // Lookup-only cycle with expectations written straight from the scenario.
  task automatic lookc(input string tag, input logic [63:0] pc, input logic e_hit,
                       input logic e_tk, input logic [63:0] e_tgt);
    drive(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    check_model();
    chk({tag, "_hit"}, 64'(pred_hit), 64'(e_hit));
    chk({tag, "_taken"}, 64'(pred_taken), 64'(e_tk));
    chk({tag, "_target"}, pred_target, e_tgt);
    @(posedge clk);
    model_edge();
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] pc;
    if ($urandom_range(0, 15) == 0) return 64'hFFFF_FFFF_FFFF_FFFD;
    pc = 64'($urandom_range(0, 2)) << 6;
    pc = pc | (64'($urandom_range(0, NENT - 1)) << 2) | 64'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) pc = pc | 64'hFFFF_FFFF_FFC0_0000;
    return pc;
  endfunction

  initial begin
    rst = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 64'h100;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    flush_all = 1'b0; upd_pred_taken = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("in_rst_hit", 64'(pred_hit), 64'd0);
    chk("in_rst_target", pred_target, 64'h104);
    @(negedge clk);
    #2 rst = 1'b1;

    lookc("rst_look", 64'h100, 1'b0, 1'b0, 64'h104);
    step(0, '0, 1, 64'h100, 1, 64'h80, 0, 0);
    lookc("alloc", 64'h100, 1'b1, 1'b1, 64'h80);
    step(0, '0, 1, 64'h100, 1, 64'h80, 0, 1);
    step(0, '0, 1, 64'h100, 1, 64'h80, 0, 1);
    step(0, '0, 1, 64'h100, 0, 64'h0, 0, 1);
    step(0, '0, 1, 64'h100, 0, 64'h0, 0, 1);
    lookc("ctr01", 64'h100, 1'b1, 1'b0, 64'h104);
    step(0, '0, 1, 64'h100, 0, 64'h0, 0, 0);
    step(0, '0, 1, 64'h100, 0, 64'h0, 0, 0);
    step(0, '0, 1, 64'h100, 1, 64'h80, 0, 0);
    lookc("ctr00_up", 64'h100, 1'b1, 1'b0, 64'h104);

    step(0, '0, 1, 64'h140, 1, 64'h200, 0, 0);
    lookc("alias_old", 64'h100, 1'b0, 1'b0, 64'h104);
    lookc("alias_new", 64'h140, 1'b1, 1'b1, 64'h200);
    step(0, '0, 1, 64'h180, 0, 64'h0, 0, 0);
    lookc("nt_miss", 64'h140, 1'b1, 1'b1, 64'h200);

    step(1, 64'h140, 1, 64'h40, 1, 64'h10, 1, 0);
    lookc("flush_40", 64'h40, 1'b0, 1'b0, 64'h44);
    lookc("flush_140", 64'h140, 1'b0, 1'b0, 64'h144);

    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), rand_pc(),
           1'($urandom_range(0, 3) != 0), rand_pc(), 1'($urandom_range(0, 2) != 0),
           {$urandom, $urandom}, 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset between edges must clear the hit before the next edge.
    step(0, '0, 1, 64'h140, 1, 64'h200, 0, 0);
    drive(1'b1, 64'h140, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("pre_async_hit", 64'(pred_hit), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_hit", 64'(pred_hit), 64'd0);
    chk("async_rst_target", pred_target, 64'h144);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b1;

    lookc("post_rst", 64'h140, 1'b0, 1'b0, 64'h144);
    lookc("post_rst2", 64'h100, 1'b0, 1'b0, 64'h104);
    lookc("post_rst3", 64'h40, 1'b0, 1'b0, 64'h44);
    step(0, '0, 1, 64'h100, 0, 64'h0, 0, 1);
    step(0, '0, 1, 64'h100, 1, 64'h80, 0, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    check_model();
`ifdef BTB_STATS_EN
    chk("stats_lookups3", 64'(stat_lookups), 64'd3);
    chk("stats_updates2", 64'(stat_updates), 64'd2);
    chk("stats_mispred1", 64'(stat_mispred), 64'd1);
    force dut.stat_lookups_q = 32'hFFFF_FFFD;
    #1 release dut.stat_lookups_q;
    m_lk = 64'sh0_FFFF_FFFD;
    @(posedge clk);
    model_edge();
    for (int n = 0; n < 5; n++) lookc("sat", 64'h200, 1'b0, 1'b0, 64'h204);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("stats_lookups_sat", 64'(stat_lookups), 64'h0000_0000_FFFF_FFFF);
`else
    @(posedge clk);
    model_edge();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
